// File: rtl/lamp_pkg.sv
// lamp_pkg: shared state/command encodings and width helpers for the lamp sequencer
package lamp_pkg;

    localparam int NUM_LAMP_DEF = 16;
    localparam int DIV_W_DEF    = 8;
    localparam int MAX_KICK_DEF = 3;

    typedef enum logic [2:0] {
        IDLE, S_UP_A, S_DN_A, S_UP_B, S_DN_B, S_UP_C, S_DN_C, DONE
    } state_e;

    // bit 1 drives the bar's up line, bit 0 its down line; both high clears the bar
    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_DOWN = 2'b01,
        CMD_UP   = 2'b10,
        CMD_CLR  = 2'b11
    } cmd_e;

    // level/bound width able to hold 0..n
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic logic is_up(input state_e s);
        return s == S_UP_A || s == S_UP_B || s == S_UP_C;
    endfunction

    function automatic logic is_dn(input state_e s);
        return s == S_DN_A || s == S_DN_B || s == S_DN_C;
    endfunction

endpackage

// File: rtl/lamp_seq_ctrl_if.sv
// lamp_seq_ctrl_if: host-side control/config and bar-side command signals of the lamp sequencer
//   master : host view (drives start/abort/flick/config, observes commands and status)
//   slave  : sequencer view
interface lamp_seq_ctrl_if
    import lamp_pkg::*;
#(
    parameter int CNT_W = cnt_width(NUM_LAMP_DEF),
    parameter int DIV_W = DIV_W_DEF
);
    logic             start;
    logic             abort;
    logic             flick;
    logic [DIV_W-1:0] period;
    logic [CNT_W-1:0] peak_a;
    logic [CNT_W-1:0] floor_a;
    logic [CNT_W-1:0] peak_b;
    logic [CNT_W-1:0] peak_c;
    logic             up;
    logic             down;
    logic [CNT_W-1:0] level;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, abort, flick, period, peak_a, floor_a, peak_b, peak_c,
        input  up, down, level, busy, done, err
    );

    modport slave (
        input  start, abort, flick, period, peak_a, floor_a, peak_b, peak_c,
        output up, down, level, busy, done, err
    );
endinterface

// File: rtl/lamp_step_timer.sv
// lamp_step_timer: step prescaler; tick_o flags that a step is due in the following cycle
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : latch period_i and restart the count (run acceptance)
//   en_i       : count enable (run in progress)
//   period_i   : step period minus 1
//   tick_o     : one-cycle step request, registered into a command by the caller
module lamp_step_timer
    import lamp_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] period_i,
    output logic             tick_o
);
    logic [DIV_W-1:0] per_q, cnt_q, cnt_d;

    // The acceptance cycle counts as the first prescaler cycle, so the load
    // value is period-1 and period 0 requests a step straight away.
    always_comb begin
        tick_o = load_i ? period_i == '0 : en_i && cnt_q == '0;
        cnt_d  = load_i ? (period_i == '0 ? '0 : period_i - 1'b1) :
                 !en_i  ? cnt_q :
                 cnt_q == '0 ? per_q : cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_q <= '0;
            cnt_q <= '0;
        end else begin
            if (load_i) per_q <= period_i;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/lamp_seq_ctrl.sv
// lamp_seq_ctrl: three-pass up/down bounce sequencer driving a lamp shift-register bar
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : lamp_seq_ctrl_if.slave -- start/abort/flick and config in; up/down/level/busy/done/err out
module lamp_seq_ctrl
    import lamp_pkg::*;
#(
    parameter int NUM_LAMP = NUM_LAMP_DEF,
    parameter int CNT_W    = cnt_width(NUM_LAMP),
    parameter int DIV_W    = DIV_W_DEF,
    parameter int MAX_KICK = MAX_KICK_DEF
) (
    input logic            clk,
    input logic            rst_n,
    lamp_seq_ctrl_if.slave bus
);
    localparam int               KICK_W = $clog2(MAX_KICK + 1);
    localparam logic [CNT_W-1:0] TOP    = CNT_W'(NUM_LAMP);

    state_e            state_q, state_d;
    cmd_e              cmd_q, cmd_d;
    logic [CNT_W-1:0]  level_q, level_d, lvl_nxt, tgt;
    logic [CNT_W-1:0]  pk_a_q, fl_a_q, pk_b_q, pk_c_q;
    logic [KICK_W-1:0] kick_q, kick_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic              load, tick, valid, reach, kick_ok, clr;

    lamp_step_timer #(.DIV_W(DIV_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .en_i     (busy_q),
        .period_i (bus.period),
        .tick_o   (tick)
    );

    always_comb begin
        valid   = bus.floor_a < bus.peak_a && bus.peak_a <= TOP &&
                  bus.floor_a < bus.peak_b && bus.peak_b <= TOP &&
                  bus.peak_c != '0 && bus.peak_c <= TOP;
        // level after the bar samples the command currently on the wires
        lvl_nxt = cmd_q == CMD_UP ? level_q + 1'b1 : cmd_q == CMD_DOWN ? level_q - 1'b1 : level_q;
        tgt     = state_q == S_UP_A ? pk_a_q : state_q == S_DN_A ? fl_a_q :
                  state_q == S_UP_B ? pk_b_q : state_q == S_UP_C ? pk_c_q : '0;
        reach   = (cmd_q == CMD_UP || cmd_q == CMD_DOWN) && lvl_nxt == tgt;
        kick_ok = bus.flick && kick_q < KICK_W'(MAX_KICK);
        clr     = busy_q && bus.abort;
        load    = state_q == IDLE && bus.start && valid;
        state_d = state_q;
        kick_d  = kick_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        level_d = lvl_nxt;
        if (load) begin
            state_d = S_UP_A;
            busy_d  = 1'b1;
            kick_d  = '0;
        end else if (state_q == IDLE) begin
            err_d = bus.start;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end else if (clr) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            level_d = '0;
        end else if (reach) begin
            case (state_q)
                S_UP_A:  state_d = S_DN_A;
                S_DN_A:  state_d = kick_ok ? S_UP_A : S_UP_B;
                S_UP_B:  state_d = S_DN_B;
                S_DN_B:  state_d = kick_ok ? S_UP_B : S_UP_C;
                S_UP_C:  state_d = S_DN_C;
                default: begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            endcase
            if ((state_q == S_DN_A || state_q == S_DN_B) && kick_ok) kick_d = kick_q + 1'b1;
        end
        // direction comes from the next state, so a turn costs no dead cycle
        cmd_d = clr ? CMD_CLR : !tick ? CMD_NOP :
                is_up(state_d) ? CMD_UP : is_dn(state_d) ? CMD_DOWN : CMD_NOP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cmd_q   <= CMD_NOP;
            level_q <= '0;
            kick_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            pk_a_q  <= '0;
            fl_a_q  <= '0;
            pk_b_q  <= '0;
            pk_c_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            level_q <= level_d;
            kick_q  <= kick_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (load) begin
                pk_a_q <= bus.peak_a;
                fl_a_q <= bus.floor_a;
                pk_b_q <= bus.peak_b;
                pk_c_q <= bus.peak_c;
            end
        end
    end

    assign bus.up    = cmd_q[1];
    assign bus.down  = cmd_q[0];
    assign bus.level = level_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_lamp_seq_ctrl.sv
// tb_lamp_seq_ctrl: directed self-checking bench for lamp_seq_ctrl
module tb_lamp_seq_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lamp_seq_ctrl_if #(.CNT_W(5), .DIV_W(8)) bus ();

    lamp_seq_ctrl #(.NUM_LAMP(16), .CNT_W(5), .DIV_W(8), .MAX_KICK(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0       = 0;
    int nstrobe, first_at, last_at, done_at, ndone, nclr, lvl_bad, nseg;
    int lvl_m    = 0;
    int seg_len [16];
    logic seg_up [16];

    always @(posedge clk) cyc <= cyc + 1;

    // strobe log, segment run lengths and an independent lit-lamp model
    always @(negedge clk) begin
        if (!rst_n) begin
            lvl_m = 0;
        end else begin
            if (bus.up && bus.down) begin
                lvl_m = 0;
                nclr++;
            end
            if (int'(bus.level) != lvl_m) lvl_bad++;
            if (bus.up ^ bus.down) begin
                nstrobe++;
                if (nstrobe == 1) first_at = cyc - t0;
                last_at = cyc - t0;
                lvl_m += bus.up ? 1 : -1;
                if (nseg == 0) begin
                    seg_up[0]  = bus.up;
                    seg_len[0] = 1;
                    nseg       = 1;
                end else if (seg_up[nseg-1] != bus.up) begin
                    if (nseg < 16) begin
                        seg_up[nseg]  = bus.up;
                        seg_len[nseg] = 1;
                        nseg++;
                    end
                end else begin
                    seg_len[nseg-1]++;
                end
            end
            if (bus.done) begin
                ndone++;
                done_at = cyc - t0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_log();
        nstrobe  = 0;
        nseg     = 0;
        first_at = -1;
        last_at  = -1;
        done_at  = -1;
        ndone    = 0;
        nclr     = 0;
        lvl_bad  = 0;
    endtask

    task automatic start_run(input int per, input int pa, input int fa, input int pb, input int pc);
        bus.period  = 8'(per);
        bus.peak_a  = 5'(pa);
        bus.floor_a = 5'(fa);
        bus.peak_b  = 5'(pb);
        bus.peak_c  = 5'(pc);
        bus.start   = 1'b1;
        clr_log();
        t0 = cyc;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done) break;
        end
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_busy_at_done"}, bus.busy, 0);
        chk({tag, "_level_at_done"}, bus.level, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_a [6];
        exp_a = '{16, 11, 5, 10, 5, 5};
        bus.start = 0; bus.abort = 0; bus.flick = 0; bus.period = 0;
        bus.peak_a = 16; bus.floor_a = 5; bus.peak_b = 10; bus.peak_c = 5;
        clr_log();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_up", bus.up, 0);
        chk("rst_down", bus.down, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // default bounce, one step per cycle
        start_run(0, 16, 5, 10, 5);
        wait_done(100, "a");
        chk("a_strobes", nstrobe, 52);
        chk("a_first", first_at, 1);
        chk("a_done_at", done_at, 53);
        chk("a_ndone", ndone, 1);
        chk("a_no_clr", nclr, 0);
        chk("a_level_track", lvl_bad, 0);
        chk("a_nseg", nseg, 6);
        chk("a_seg0_up", seg_up[0], 1);
        for (int i = 0; i < 6; i++) chk($sformatf("a_seg%0d", i), seg_len[i], exp_a[i]);

        // period 3, with a start attempt and new config mid-run
        start_run(3, 16, 5, 10, 5);
        repeat (40) @(posedge clk);
        #1;
        bus.peak_a = 3; bus.floor_a = 0; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(400, "b");
        chk("b_strobes", nstrobe, 52);
        chk("b_first", first_at, 4);
        chk("b_last", last_at, 208);
        chk("b_done_at", done_at, 209);
        chk("b_nseg", nseg, 6);
        chk("b_seg0", seg_len[0], 16);

        // flick held high: three kick-backs at floor_a, none left for the second floor
        bus.flick = 1'b1;
        start_run(0, 16, 5, 10, 5);
        wait_done(300, "f");
        bus.flick = 1'b0;
        chk("f_strobes", nstrobe, 118);
        chk("f_nseg", nseg, 12);
        chk("f_done_at", done_at, 119);
        chk("f_seg2", seg_len[2], 11);
        chk("f_seg2_up", seg_up[2], 1);
        chk("f_seg7", seg_len[7], 11);
        chk("f_seg8", seg_len[8], 5);
        chk("f_seg9", seg_len[9], 10);
        chk("f_level_track", lvl_bad, 0);

        // abort in cycle 20
        start_run(0, 16, 5, 10, 5);
        repeat (19) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        @(negedge clk);
        chk("ab_up", bus.up, 1);
        chk("ab_down", bus.down, 1);
        chk("ab_level", bus.level, 0);
        chk("ab_busy", bus.busy, 0);
        repeat (60) @(posedge clk);
        #1;
        chk("ab_no_done", ndone, 0);
        chk("ab_one_clr", nclr, 1);
        chk("ab_strobes", nstrobe, 20);
        chk("ab_idle_up", bus.up, 0);
        // start and abort together while idle: start wins
        bus.abort = 1'b1;
        start_run(0, 16, 5, 10, 5);
        wait_done(100, "r");
        chk("r_strobes", nstrobe, 52);
        chk("r_done_at", done_at, 53);

        // invalid configurations
        start_run(0, 7, 7, 10, 5);
        @(negedge clk);
        chk("inv_err", bus.err, 1);
        chk("inv_busy", bus.busy, 0);
        @(negedge clk);
        chk("inv_err_pulse", bus.err, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("inv_strobes", nstrobe, 0);
        start_run(0, 16, 5, 10, 0);
        @(negedge clk);
        chk("inv_pc0_err", bus.err, 1);
        start_run(0, 16, 5, 17, 5);
        @(negedge clk);
        chk("inv_pb17_err", bus.err, 1);
        @(posedge clk);
        #1;

        // asynchronous reset in the middle of the second climb
        start_run(0, 16, 5, 10, 5);
        repeat (29) @(posedge clk);
        #1;
        chk("rm_level_pre", bus.level, 7);
        chk("rm_up_pre", bus.up, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rm_up", bus.up, 0);
        chk("rm_level", bus.level, 0);
        chk("rm_busy", bus.busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rm_idle", bus.busy, 0);
        start_run(0, 16, 5, 10, 5);
        wait_done(100, "rr");
        chk("rr_strobes", nstrobe, 52);
        chk("rr_level_track", lvl_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
